// File: rtl/branch_predict_unit_pkg.sv
// Shared types and helpers for the branch predict unit.
//   btb_entry_t : one BTB line (valid, tag, predicted target)
//   bp_state_e  : top-level run/halt state
//   wr_op_e     : training operation applied to one BTB line
//   sat_update  : 2-bit saturating direction counter step
package bp_pkg;

  // Default geometry. The struct tag width follows these, so a top-level
  // override of PC_W/IDX_W must be mirrored here.
  localparam int BP_PC_W  = 9;
  localparam int BP_IDX_W = 4;
  localparam int BP_TAG_W = BP_PC_W - BP_IDX_W - 2;

  localparam logic [1:0] CTR_SNT = 2'd0;
  localparam logic [1:0] CTR_WNT = 2'd1;
  localparam logic [1:0] CTR_WT  = 2'd2;
  localparam logic [1:0] CTR_ST  = 2'd3;

  typedef struct packed {
    logic                valid;
    logic [BP_TAG_W-1:0] tag;
    logic [31:0]         target;
  } btb_entry_t;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } bp_state_e;

  typedef enum logic [1:0] {
    WR_NONE   = 2'd0,
    WR_BRANCH = 2'd1,
    WR_JAL    = 2'd2,
    WR_INV    = 2'd3
  } wr_op_e;

  function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == CTR_ST)  ? CTR_ST  : ctr + 2'd1;
    else       return (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/branch_predict_unit_if.sv
// Bus between the pipeline (master: PC register + execute stage) and the
// branch predict unit (slave).
//   fetch   : f_pc -> pred_taken, pred_target
//   execute : ex_* -> pc_four, jsel, redirect, redirect_pc
//   status  : halted, stat_branches, stat_mispredicts
interface branch_predict_unit_if #(
  parameter int PC_W   = 9,
  parameter int STAT_W = 32
);
  logic [PC_W-1:0]   f_pc;
  logic              pred_taken;
  logic [31:0]       pred_target;

  logic              ex_valid;
  logic [PC_W-1:0]   ex_pc;
  logic [31:0]       ex_imm;
  logic              ex_branch;
  logic              ex_jal;
  logic              ex_jalr;
  logic              ex_halt;
  logic [31:0]       ex_alu_result;
  logic              ex_pred_taken;
  logic [31:0]       ex_pred_target;

  logic [31:0]       pc_four;
  logic              jsel;
  logic              redirect;
  logic [31:0]       redirect_pc;
  logic              halted;
  logic [STAT_W-1:0] stat_branches;
  logic [STAT_W-1:0] stat_mispredicts;

  modport master (
    output f_pc, ex_valid, ex_pc, ex_imm, ex_branch, ex_jal, ex_jalr, ex_halt,
           ex_alu_result, ex_pred_taken, ex_pred_target,
    input  pred_taken, pred_target, pc_four, jsel, redirect, redirect_pc,
           halted, stat_branches, stat_mispredicts
  );

  modport slave (
    input  f_pc, ex_valid, ex_pc, ex_imm, ex_branch, ex_jal, ex_jalr, ex_halt,
           ex_alu_result, ex_pred_taken, ex_pred_target,
    output pred_taken, pred_target, pc_four, jsel, redirect, redirect_pc,
           halted, stat_branches, stat_mispredicts
  );
endinterface

// File: rtl/branch_predict_unit_btb_table.sv
// Direct-mapped BTB storage with per-line 2-bit direction counters.
//   clk, reset_n       : clock, async active-low clear (lines invalid, ctr=WNT)
//   rd_idx             : fetch-side index
//   rd_entry, rd_taken : combinational read of registered line / ctr MSB
//   wr_op, wr_idx,
//   wr_tag, wr_target,
//   wr_taken           : training op, applied at the next rising edge
// The tag compare for training is done here against the registered line, so
// a same-cycle fetch read of the line being trained sees the old contents.
module btb_table
  import bp_pkg::*;
#(
  parameter int IDX_W = BP_IDX_W
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [IDX_W-1:0]    rd_idx,
  output btb_entry_t          rd_entry,
  output logic                rd_taken,
  input  wr_op_e              wr_op,
  input  logic [IDX_W-1:0]    wr_idx,
  input  logic [BP_TAG_W-1:0] wr_tag,
  input  logic [31:0]         wr_target,
  input  logic                wr_taken
);

  localparam int N = 1 << IDX_W;

  btb_entry_t ent_q [N];
  btb_entry_t ent_d [N];
  logic [1:0] ctr_q [N];
  logic [1:0] ctr_d [N];
  logic       wr_hit;

  assign rd_entry = ent_q[rd_idx];
  assign rd_taken = ctr_q[rd_idx][1];

  always_comb begin
    ent_d  = ent_q;
    ctr_d  = ctr_q;
    wr_hit = ent_q[wr_idx].valid && (ent_q[wr_idx].tag == wr_tag);
    unique case (wr_op)
      WR_BRANCH: begin
        if (wr_hit) begin
          ent_d[wr_idx].target = wr_target;
          ctr_d[wr_idx]        = sat_update(ctr_q[wr_idx], wr_taken);
        end else if (wr_taken) begin
          // Only taken branches allocate, so a fresh line always starts WT.
          ent_d[wr_idx] = '{valid: 1'b1, tag: wr_tag, target: wr_target};
          ctr_d[wr_idx] = CTR_WT;
        end
      end
      WR_JAL: begin
        ent_d[wr_idx] = '{valid: 1'b1, tag: wr_tag, target: wr_target};
        ctr_d[wr_idx] = CTR_ST;
      end
      WR_INV: begin
        if (wr_hit) ent_d[wr_idx].valid = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) begin
        ent_q[i] <= '0;
        ctr_q[i] <= CTR_WNT;
      end
    end else begin
      ent_q <= ent_d;
      ctr_q <= ctr_d;
    end
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch predict unit: BTB-based next-PC prediction at fetch, resolution of
// branch/JAL/JALR/HALT at execute with redirect on mispredict, BTB training,
// halt state and statistics.
//   clk, reset_n : clock, async active-low reset
//   bp (slave)   : fetch, execute and status signals (branch_predict_unit_if)
//
// state  | meaning
// RUN    | normal operation: predict, resolve, train, count
// HALTED | halt retired: redirect to halt_pc every cycle, tables/stats frozen
module branch_predict_unit
  import bp_pkg::*;
#(
  parameter int PC_W   = BP_PC_W,
  parameter int IDX_W  = BP_IDX_W,
  parameter int STAT_W = 32
) (
  input  logic clk,
  input  logic reset_n,
  branch_predict_unit_if.slave bp
);

  localparam int TAG_W = PC_W - IDX_W - 2;

  bp_state_e         state_q, state_d;
  logic [PC_W-1:0]   halt_pc_q, halt_pc_d;
  logic [STAT_W-1:0] stat_br_q, stat_br_d;
  logic [STAT_W-1:0] stat_mp_q, stat_mp_d;

  // Fetch side
  logic [IDX_W-1:0] f_idx;
  logic [TAG_W-1:0] f_tag;
  btb_entry_t       f_ent;
  logic             f_dir;
  logic [31:0]      f_pc4;
  logic             f_pred;

  assign f_idx  = bp.f_pc[IDX_W+1:2];
  assign f_tag  = bp.f_pc[PC_W-1:IDX_W+2];
  assign f_pc4  = 32'(bp.f_pc) + 32'd4;
  assign f_pred = (state_q == RUN) && f_ent.valid && (f_ent.tag == f_tag) && f_dir;

  assign bp.pred_taken  = f_pred;
  assign bp.pred_target = f_pred ? f_ent.target : f_pc4;

  // Execute side
  logic [31:0]      ex_pc32;
  logic [31:0]      ex_pc4;
  logic [31:0]      ex_target;
  logic             is_ctl;
  logic             act_taken;
  logic             mispredict;
  logic [IDX_W-1:0] ex_idx;
  logic [TAG_W-1:0] ex_tag;

  assign ex_pc32   = 32'(bp.ex_pc);
  assign ex_pc4    = ex_pc32 + 32'd4;
  assign ex_idx    = bp.ex_pc[IDX_W+1:2];
  assign ex_tag    = bp.ex_pc[PC_W-1:IDX_W+2];
  assign is_ctl    = bp.ex_branch | bp.ex_jal | bp.ex_jalr;
  assign act_taken = (bp.ex_branch & bp.ex_alu_result[0]) | bp.ex_jal | bp.ex_jalr;
  assign ex_target = bp.ex_jalr ? (bp.ex_alu_result & ~32'h1) : (ex_pc32 + bp.ex_imm);
  // A non-control instruction predicted taken falls out of the first term.
  assign mispredict = (act_taken != bp.ex_pred_taken) ||
                      (act_taken && (bp.ex_pred_target != ex_target));

  assign bp.pc_four = ex_pc4;
  assign bp.jsel    = bp.ex_jal | bp.ex_jalr;

  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halted;
  wr_op_e      wr_op;

  always_comb begin
    state_d     = state_q;
    halt_pc_d   = halt_pc_q;
    stat_br_d   = stat_br_q;
    stat_mp_d   = stat_mp_q;
    redirect    = 1'b0;
    redirect_pc = act_taken ? ex_target : ex_pc4;
    halted      = 1'b0;
    wr_op       = WR_NONE;
    unique case (state_q)
      RUN: begin
        if (bp.ex_valid) begin
          if (bp.ex_halt) begin
            redirect    = 1'b1;
            redirect_pc = ex_pc32;
            halt_pc_d   = bp.ex_pc;
            state_d     = HALTED;
            stat_mp_d   = stat_mp_q + STAT_W'(1);
          end else begin
            redirect = mispredict;
            if (is_ctl)     stat_br_d = stat_br_q + STAT_W'(1);
            if (mispredict) stat_mp_d = stat_mp_q + STAT_W'(1);
            // JALR and plain instructions only ever remove an aliasing line.
            if (bp.ex_branch)   wr_op = WR_BRANCH;
            else if (bp.ex_jal) wr_op = WR_JAL;
            else                wr_op = WR_INV;
          end
        end
      end
      HALTED: begin
        halted      = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'(halt_pc_q);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= RUN;
      halt_pc_q <= '0;
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else begin
      state_q   <= state_d;
      halt_pc_q <= halt_pc_d;
      stat_br_q <= stat_br_d;
      stat_mp_q <= stat_mp_d;
    end
  end

  btb_table #(.IDX_W(IDX_W)) u_btb (
    .clk       (clk),
    .reset_n   (reset_n),
    .rd_idx    (f_idx),
    .rd_entry  (f_ent),
    .rd_taken  (f_dir),
    .wr_op     (wr_op),
    .wr_idx    (ex_idx),
    .wr_tag    (ex_tag),
    .wr_target (ex_target),
    .wr_taken  (act_taken)
  );

  assign bp.redirect         = redirect;
  assign bp.redirect_pc      = redirect_pc;
  assign bp.halted           = halted;
  assign bp.stat_branches    = stat_br_q;
  assign bp.stat_mispredicts = stat_mp_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
module tb_branch_predict_unit;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  branch_predict_unit_if #(.PC_W(9), .STAT_W(32)) bus ();

  branch_predict_unit #(.PC_W(9), .IDX_W(4), .STAT_W(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bp      (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [8:0]  f_pc;
    logic        v;
    logic [8:0]  pc;
    logic [31:0] imm;
    logic        br, jal, jalr;
    logic [31:0] alu;
    logic        ppt;
    logic [31:0] ptgt;
    logic        e_pt;
    logic [31:0] e_ptgt;
    logic        e_redir;
    logic [31:0] e_rpc;
    logic [31:0] e_pc4;
    logic        e_jsel;
    logic [31:0] e_br;
    logic [31:0] e_mp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    logic [8:0] f_pc, logic v, logic [8:0] pc, logic [31:0] imm,
    logic br, logic jal, logic jalr, logic [31:0] alu, logic ppt, logic [31:0] ptgt,
    logic e_pt, logic [31:0] e_ptgt, logic e_redir, logic [31:0] e_rpc,
    logic [31:0] e_pc4, logic e_jsel, logic [31:0] e_br, logic [31:0] e_mp);
    vec_t r;
    r.f_pc = f_pc; r.v = v; r.pc = pc; r.imm = imm; r.br = br; r.jal = jal; r.jalr = jalr;
    r.alu = alu; r.ppt = ppt; r.ptgt = ptgt; r.e_pt = e_pt; r.e_ptgt = e_ptgt;
    r.e_redir = e_redir; r.e_rpc = e_rpc; r.e_pc4 = e_pc4; r.e_jsel = e_jsel;
    r.e_br = e_br; r.e_mp = e_mp;
    return r;
  endfunction

  task automatic drive_ex(input logic v, input logic [8:0] pc, input logic [31:0] imm,
                          input logic br, input logic jal, input logic jalr, input logic halt,
                          input logic [31:0] alu, input logic ppt, input logic [31:0] ptgt);
    bus.ex_valid = v; bus.ex_pc = pc; bus.ex_imm = imm;
    bus.ex_branch = br; bus.ex_jal = jal; bus.ex_jalr = jalr; bus.ex_halt = halt;
    bus.ex_alu_result = alu; bus.ex_pred_taken = ppt; bus.ex_pred_target = ptgt;
  endtask

  initial begin
    //         f_pc   v  pc     imm           br jal jalr alu         ppt ptgt      | pt tgt    redir rpc    pc4    jsel br mp
    vecs.push_back(mk(9'h010, 0, 9'h000, 32'h0,        0, 0, 0, 32'h0,     0, 32'h0,      0, 32'h14, 0, 32'h0,   32'h04, 0, 0, 0)); // reset state
    vecs.push_back(mk(9'h010, 1, 9'h010, 32'h20,       1, 0, 0, 32'h1,     0, 32'h0,      0, 32'h14, 1, 32'h30,  32'h14, 0, 1, 1)); // cold taken branch
    vecs.push_back(mk(9'h010, 1, 9'h010, 32'h20,       1, 0, 0, 32'h1,     1, 32'h30,     1, 32'h30, 0, 32'h0,   32'h14, 0, 2, 1));
    vecs.push_back(mk(9'h010, 1, 9'h010, 32'h20,       1, 0, 0, 32'h1,     1, 32'h30,     1, 32'h30, 0, 32'h0,   32'h14, 0, 3, 1));
    vecs.push_back(mk(9'h010, 1, 9'h010, 32'h20,       1, 0, 0, 32'h1,     1, 32'h30,     1, 32'h30, 0, 32'h0,   32'h14, 0, 4, 1)); // ctr saturated 3
    vecs.push_back(mk(9'h010, 1, 9'h010, 32'h20,       1, 0, 0, 32'h0,     1, 32'h30,     1, 32'h30, 1, 32'h14,  32'h14, 0, 5, 2)); // not taken -> ctr 2
    vecs.push_back(mk(9'h010, 0, 9'h000, 32'h0,        0, 0, 0, 32'h0,     0, 32'h0,      1, 32'h30, 0, 32'h0,   32'h04, 0, 5, 2)); // still taken
    vecs.push_back(mk(9'h040, 1, 9'h040, 32'h0,        0, 0, 1, 32'h107,   0, 32'h0,      0, 32'h44, 1, 32'h106, 32'h44, 1, 6, 3)); // JALR
    vecs.push_back(mk(9'h040, 0, 9'h000, 32'h0,        0, 0, 0, 32'h0,     0, 32'h0,      0, 32'h44, 0, 32'h0,   32'h04, 0, 6, 3)); // no JALR alloc
    vecs.push_back(mk(9'h020, 1, 9'h020, 32'hFFFFFFF0, 0, 1, 0, 32'h0,     0, 32'h0,      0, 32'h24, 1, 32'h10,  32'h24, 1, 7, 4)); // JAL backward
    vecs.push_back(mk(9'h020, 0, 9'h000, 32'h0,        0, 0, 0, 32'h0,     0, 32'h0,      1, 32'h10, 0, 32'h0,   32'h04, 0, 7, 4)); // JAL allocated
    vecs.push_back(mk(9'h020, 1, 9'h020, 32'h0,        0, 0, 0, 32'h0,     1, 32'h10,     1, 32'h10, 1, 32'h24,  32'h24, 0, 7, 5)); // alias on plain insn
    vecs.push_back(mk(9'h020, 0, 9'h000, 32'h0,        0, 0, 0, 32'h0,     0, 32'h0,      0, 32'h24, 0, 32'h0,   32'h04, 0, 7, 5)); // invalidated
    vecs.push_back(mk(9'h050, 1, 9'h050, 32'h8,        1, 0, 0, 32'h0,     0, 32'h0,      0, 32'h54, 0, 32'h0,   32'h54, 0, 8, 5)); // NT miss, tag differs
    vecs.push_back(mk(9'h050, 0, 9'h000, 32'h0,        0, 0, 0, 32'h0,     0, 32'h0,      0, 32'h54, 0, 32'h0,   32'h04, 0, 8, 5)); // no alloc
    vecs.push_back(mk(9'h010, 0, 9'h000, 32'h0,        0, 0, 0, 32'h0,     0, 32'h0,      1, 32'h30, 0, 32'h0,   32'h04, 0, 8, 5)); // entry intact
    vecs.push_back(mk(9'h010, 1, 9'h010, 32'h20,       1, 0, 0, 32'h1,     1, 32'h34,     1, 32'h30, 1, 32'h30,  32'h14, 0, 9, 6)); // wrong target
    vecs.push_back(mk(9'h060, 0, 9'h060, 32'h10,       0, 1, 0, 32'h0,     0, 32'h0,      0, 32'h64, 0, 32'h0,   32'h64, 1, 9, 6)); // invalid JAL
    vecs.push_back(mk(9'h060, 0, 9'h000, 32'h0,        0, 0, 0, 32'h0,     0, 32'h0,      0, 32'h64, 0, 32'h0,   32'h04, 0, 9, 6)); // nothing trained

    reset_n = 1'b0;
    bus.f_pc = 9'h010;
    drive_ex(0, 9'h0, 32'h0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      bus.f_pc = vecs[i].f_pc;
      drive_ex(vecs[i].v, vecs[i].pc, vecs[i].imm, vecs[i].br, vecs[i].jal, vecs[i].jalr, 1'b0,
               vecs[i].alu, vecs[i].ppt, vecs[i].ptgt);
      #1;
      chk($sformatf("v%0d_pred_taken", i), 32'(bus.pred_taken), 32'(vecs[i].e_pt));
      chk($sformatf("v%0d_pred_target", i), bus.pred_target, vecs[i].e_ptgt);
      chk($sformatf("v%0d_redirect", i), 32'(bus.redirect), 32'(vecs[i].e_redir));
      if (vecs[i].e_redir)
        chk($sformatf("v%0d_redirect_pc", i), bus.redirect_pc, vecs[i].e_rpc);
      chk($sformatf("v%0d_pc_four", i), bus.pc_four, vecs[i].e_pc4);
      chk($sformatf("v%0d_jsel", i), 32'(bus.jsel), 32'(vecs[i].e_jsel));
      chk($sformatf("v%0d_halted", i), 32'(bus.halted), 32'h0);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_stat_branches", i), bus.stat_branches, vecs[i].e_br);
      chk($sformatf("v%0d_stat_mispredicts", i), bus.stat_mispredicts, vecs[i].e_mp);
    end

    // Halt: redirect to the halt PC in the halt cycle, then hold it.
    @(negedge clk);
    bus.f_pc = 9'h010;
    drive_ex(1, 9'h080, 32'h0, 0, 0, 0, 1, 32'h0, 0, 32'h0);
    #1;
    chk("halt_cycle_redirect", 32'(bus.redirect), 32'h1);
    chk("halt_cycle_redirect_pc", bus.redirect_pc, 32'h80);
    chk("halt_cycle_halted", 32'(bus.halted), 32'h0);
    @(posedge clk);
    #1;
    chk("halt_halted", 32'(bus.halted), 32'h1);
    chk("halt_stat_branches", bus.stat_branches, 32'd9);
    chk("halt_stat_mispredicts", bus.stat_mispredicts, 32'd7);
    @(negedge clk);
    drive_ex(1, 9'h070, 32'h4, 1, 0, 0, 0, 32'h1, 0, 32'h0);
    for (int c = 0; c < 10; c++) begin
      #1;
      chk($sformatf("halted_c%0d_redirect", c), 32'(bus.redirect), 32'h1);
      chk($sformatf("halted_c%0d_redirect_pc", c), bus.redirect_pc, 32'h80);
      chk($sformatf("halted_c%0d_halted", c), 32'(bus.halted), 32'h1);
      chk($sformatf("halted_c%0d_pred_taken", c), 32'(bus.pred_taken), 32'h0);
      @(negedge clk);
    end
    chk("halted_stat_branches", bus.stat_branches, 32'd9);
    chk("halted_stat_mispredicts", bus.stat_mispredicts, 32'd7);

    // Async reset pulse between edges clears everything before the next edge.
    #1 reset_n = 1'b0;
    drive_ex(0, 9'h0, 32'h0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
    #1;
    chk("areset_halted", 32'(bus.halted), 32'h0);
    chk("areset_redirect", 32'(bus.redirect), 32'h0);
    chk("areset_stat_branches", bus.stat_branches, 32'h0);
    chk("areset_stat_mispredicts", bus.stat_mispredicts, 32'h0);
    #1 reset_n = 1'b1;
    bus.f_pc = 9'h010;
    #1;
    chk("areset_pred_taken", 32'(bus.pred_taken), 32'h0);
    chk("areset_pred_target", bus.pred_target, 32'h14);
    chk("areset_halted_after", 32'(bus.halted), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
